// File: rtl/score_display_driver.sv
// score_display_driver
//   Converts the scoreboard counter's binary value (clamped to 0..99) into two
//   BCD digits using a sequential double-dabble engine. It then drives a
//   two-digit multiplexed 7-segment display.
//
// Ports
//   clk_i   : system clock, rising-edge active
//   rst_i   : synchronous, active-low reset
//   val_i   : binary score value from the counter (BW bits)
//   seg_o   : segment drive {g,f,e,d,c,b,a}, active-high
//   dig_o   : one-hot digit select, bit0 = ones, bit1 = tens
//   bcd_o   : committed BCD value, [7:4] = tens, [3:0] = ones
//   busy_o  : high while a conversion is in progress
//
// BW is assumed to be at least 7, so that the clamp constant 99 fits.
module score_display_driver #(
  parameter int unsigned BW          = 7,
  parameter int unsigned REFRESH_DIV = 16,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] val_i,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_o,
  output logic [7:0]    bcd_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

  state_t      r_state;
  logic [6:0]  r_last;
  logic [6:0]  r_shift;
  logic [7:0]  r_scratch;
  logic [2:0]  r_iter;
  logic [7:0]  r_bcd;
  logic        r_busy;
  logic [15:0] r_cnt;
  logic        r_sel;
  logic [6:0]  r_seg;
  logic [1:0]  r_dig;

  logic [6:0]  w_clamped;
  logic [3:0]  w_tens_adj;
  logic [3:0]  w_ones_adj;
  logic [3:0]  w_nib;
  logic [6:0]  w_dec;

  // Values above 99 saturate, so 100..127 all look like 99 to the FSM.
  assign w_clamped = (val_i > BW'(99)) ? 7'd99 : 7'(val_i);

  // Double-dabble add-3 correction, applied before each shift.
  always_comb begin
    w_tens_adj = r_scratch[7:4];
    w_ones_adj = r_scratch[3:0];
    if (r_scratch[7:4] >= 4'd5) w_tens_adj = r_scratch[7:4] + 4'd3;
    if (r_scratch[3:0] >= 4'd5) w_ones_adj = r_scratch[3:0] + 4'd3;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_last    <= '0;
      r_shift   <= '0;
      r_scratch <= '0;
      r_iter    <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clamped != r_last) begin
            r_shift   <= w_clamped;
            r_last    <= w_clamped;
            r_scratch <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          r_scratch <= {w_tens_adj[2:0], w_ones_adj, r_shift[6]};
          r_shift   <= {r_shift[5:0], 1'b0};
          r_iter    <= r_iter + 3'd1;
          if (r_iter == 3'd6) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_bcd   <= r_scratch;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_nib = r_sel ? r_bcd[7:4] : r_bcd[3:0];

  always_comb begin
    w_dec = 7'h00;
    case (w_nib)
      4'd0: w_dec = 7'h3F;
      4'd1: w_dec = 7'h06;
      4'd2: w_dec = 7'h5B;
      4'd3: w_dec = 7'h4F;
      4'd4: w_dec = 7'h66;
      4'd5: w_dec = 7'h6D;
      4'd6: w_dec = 7'h7D;
      4'd7: w_dec = 7'h07;
      4'd8: w_dec = 7'h7F;
      4'd9: w_dec = 7'h6F;
      default: w_dec = 7'h00;
    endcase
  end

  // Segment and digit outputs are registered from the same select value, so
  // they always refer to the same digit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
      r_seg <= '0;
      r_dig <= '0;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_sel <= ~r_sel;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_dig <= r_sel ? 2'b10 : 2'b01;
      if (r_sel && LZ_BLANK && (r_bcd[7:4] == 4'd0))
        r_seg <= '0;
      else
        r_seg <= w_dec;
    end
  end

  assign seg_o  = r_seg;
  assign dig_o  = r_dig;
  assign bcd_o  = r_bcd;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver. Two instances share their
// inputs: the default instance (REFRESH_DIV=16, leading-zero blanking on) and
// a second instance (REFRESH_DIV=2, no blanking). A cycle-level reference
// model predicts every output of both instances.
module tb_score_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] val = '0;

  logic [6:0] seg_a, seg_b;
  logic [1:0] dig_a, dig_b;
  logic [7:0] bcd_a, bcd_b;
  logic       busy_a, busy_b;

  int errors = 0;
  int checks = 0;
  bit model_chk = 1'b0;

  always #5 clk = ~clk;

  score_display_driver dut_a (
    .clk_i(clk), .rst_i(rst), .val_i(val),
    .seg_o(seg_a), .dig_o(dig_a), .bcd_o(bcd_a), .busy_o(busy_a)
  );

  score_display_driver #(.BW(7), .REFRESH_DIV(2), .LZ_BLANK(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .val_i(val),
    .seg_o(seg_b), .dig_o(dig_b), .bcd_o(bcd_b), .busy_o(busy_b)
  );

  // ---------------- reference model ----------------
  logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int DIVS [2] = '{16, 2};
  bit LZS  [2] = '{1'b1, 1'b0};

  int         m_last = 0, m_wait = 0, m_tgt = 0, m_k = 0;
  logic [7:0] m_bcd = '0;
  logic       m_busy = 1'b0;
  logic [1:0] e_dig [2];
  logic [6:0] e_seg [2];

  always @(posedge clk) begin
    int c, slot;
    logic [3:0] d;
    if (!rst) begin
      m_last = 0; m_wait = 0; m_bcd = '0; m_busy = 1'b0; m_k = 0;
      for (int n = 0; n < 2; n++) begin e_dig[n] = '0; e_seg[n] = '0; end
    end else begin
      // Display reflects the BCD value held before this edge.
      for (int n = 0; n < 2; n++) begin
        slot = (m_k / DIVS[n]) % 2;
        d = (slot == 1) ? m_bcd[7:4] : m_bcd[3:0];
        e_dig[n] = (slot == 1) ? 2'b10 : 2'b01;
        e_seg[n] = (slot == 1 && LZS[n] && m_bcd[7:4] == 4'd0) ? 7'h00 : SEG[d];
      end
      m_k++;
      if (m_wait == 0) begin
        c = (val > 99) ? 99 : int'(val);
        if (c != m_last) begin
          m_last = c; m_tgt = c; m_wait = 8; m_busy = 1'b1;
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_bcd  = 8'(((m_tgt / 10) << 4) + (m_tgt % 10));
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (model_chk) begin
      chk("busy_a", 32'(busy_a), 32'(m_busy));
      chk("bcd_a",  32'(bcd_a),  32'(m_bcd));
      chk("dig_a",  32'(dig_a),  32'(e_dig[0]));
      chk("seg_a",  32'(seg_a),  32'(e_seg[0]));
      chk("busy_b", 32'(busy_b), 32'(m_busy));
      chk("bcd_b",  32'(bcd_b),  32'(m_bcd));
      chk("dig_b",  32'(dig_b),  32'(e_dig[1]));
      chk("seg_b",  32'(seg_b),  32'(e_seg[1]));
    end
  endtask

  typedef struct {
    logic [6:0] val;
    int         cyc;
    logic [7:0] bcd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{7'd0,   20, 8'h00};
    vecs[1] = '{7'd42,  12, 8'h42};
    vecs[2] = '{7'd99,  12, 8'h99};
    vecs[3] = '{7'd100, 12, 8'h99};
    vecs[4] = '{7'd127, 12, 8'h99};
    vecs[5] = '{7'd7,   40, 8'h07};
    vecs[6] = '{7'd98,  12, 8'h98};
    vecs[7] = '{7'd0,   12, 8'h00};

    // Reset held for 5 cycles.
    rst = 1'b0; val = '0;
    for (int i = 0; i < 5; i++) cycle();
    model_chk = 1'b1;
    chk("rst_bcd", 32'(bcd_a), 32'h00);
    chk("rst_dig", 32'(dig_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    rst = 1'b1;
    cycle();
    chk("first_dig", 32'(dig_a), 32'h1);
    chk("first_seg", 32'(seg_a), 32'h3F);
    for (int i = 0; i < 16; i++) cycle();
    chk("tens_dig", 32'(dig_a), 32'h2);
    chk("tens_blank", 32'(seg_a), 32'h00);
    chk("idle_busy", 32'(busy_a), 32'h0);

    // Table-driven settle vectors.
    for (int v = 0; v < 8; v++) begin
      val = vecs[v].val;
      for (int i = 0; i < vecs[v].cyc; i++) cycle();
      chk($sformatf("vec%0d_bcd", v), 32'(bcd_a), 32'(vecs[v].bcd));
      chk($sformatf("vec%0d_busy", v), 32'(busy_a), 32'h0);
    end

    // Exact latency for 0 -> 42.
    val = 7'd42;
    cycle();
    chk("lat_busy_e0", 32'(busy_a), 32'h1);
    for (int i = 1; i < 8; i++) begin
      cycle();
      chk("lat_bcd_hold", 32'(bcd_a), 32'h00);
      chk("lat_busy_mid", 32'(busy_a), 32'h1);
    end
    cycle();
    chk("lat_bcd_e8", 32'(bcd_a), 32'h42);
    chk("lat_busy_e8", 32'(busy_a), 32'h0);

    // 10 -> 11 -> 12 -> 13 on consecutive cycles.
    val = 7'd10; cycle();
    val = 7'd11; cycle();
    val = 7'd12; cycle();
    val = 7'd13;
    for (int i = 3; i < 8; i++) cycle();
    cycle();
    chk("burst_first", 32'(bcd_a), 32'h10);
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("burst_no_mid", 32'(bcd_a == 8'h11 || bcd_a == 8'h12), 32'h0);
    end
    chk("burst_final", 32'(bcd_a), 32'h13);

    // Reset three cycles into a conversion of 55.
    val = 7'd55;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    cycle();
    chk("abort_bcd", 32'(bcd_a), 32'h00);
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_dig", 32'(dig_a), 32'h0);
    rst = 1'b1;
    cycle();
    chk("reconv_busy", 32'(busy_a), 32'h1);
    for (int i = 0; i < 8; i++) cycle();
    chk("reconv_bcd", 32'(bcd_a), 32'h55);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 2) val = 7'($urandom_range(0, 127));
      cycle();
    end
    for (int i = 0; i < 20; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
